nand_g_decoder: RTL and testbench
=================================

Name: nand_g_decoder

Overview:
- 2-input NAND gate combined with a 2-to-4 active-low decoder built on NAND semantics.
- Provides a zero-latency combinational NAND output plus registered NAND and decoded outputs for synchronous consumers.
- Used as a small glue/select block wherever a 2-bit code must drive active-low one-hot selects.

Parameters:
- CNT_W, 16, width of the optional low-event counter (minimum 1).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, reset; synchronous and active-low.
- a, input, 1, operand / select bit 0 (LSB).
- b, input, 1, operand / select bit 1 (MSB).
- en, input, 1, active-high enable for the registered outputs.
- nand_o, output, 1, combinational ~(a & b).
- nand_q, output, 1, registered ~(a & b).
- dec_o, output, 4, registered active-low decode of sel = {b,a}.
- valid_o, output, 1, registered; high for the cycle after an enabled sample.
- low_cnt, output, CNT_W, count of enabled samples with a=b=1 (optional feature).

Behaviour:
- nand_o: purely combinational, zero latency, independent of clk, rst_n and en.
  - Truth table (a,b -> nand_o): 00->1, 10->1, 01->1, 11->0.
- Synchronous reset: rst_n==0 at a rising edge sets nand_q=1, dec_o=4'b1111, valid_o=0, low_cnt=0. Reset has priority over en.
- Enabled sample: rst_n==1 and en==1 at a rising edge.
  - nand_q <= ~(a & b).
  - dec_o <= all ones except bit sel, which is cleared (exactly one bit low).
  - Required decode values: sel 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
  - valid_o <= 1.
- Idle cycle: rst_n==1 and en==0 at a rising edge.
  - nand_q and dec_o hold their previous values.
  - valid_o <= 0.
- Latency: one cycle from the sampled edge to nand_q, dec_o and valid_o.
- Invariant: dec_o is either 4'b1111 (reset, before the first sample) or has exactly one zero bit. nand_q==0 iff dec_o[3]==0.
- Inputs are sampled only at the clock edge; glitches between edges affect only nand_o.
- Reset mid-stream: an asserted reset overrides any same-edge enable. The first enabled edge after reset release produces normal outputs one cycle later.

Optional Feature:
- Macro: NAND_G_DECODER_STATS_EN.
- Defined: low_cnt increments by 1 on each enabled sample with a=b=1 (nand_q going/staying 0).
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared to 0 by reset.
  - Holds when en==0.
- Not defined: the low_cnt port still exists, tied to constant 0, and no counter logic is synthesized.

Test Plan:
- Hold rst_n=0 for 2 cycles with a=b=1, en=1 -> nand_q=1, dec_o=1111, valid_o=0, low_cnt=0; nand_o=0 throughout.
- Release reset, apply en=1 and step (a,b) = (0,0), (1,0), (0,1), (1,1), one per cycle.
  - nand_o immediately: 1, 1, 1, 0.
  - One cycle later, nand_q: 1, 1, 1, 0.
  - One cycle later, dec_o: 1110, 1101, 1011, 0111.
  - valid_o=1 each of those cycles.
- With dec_o=0111, drop en=0 and change a,b to 0,0 -> dec_o and nand_q hold (0111, 0), valid_o=0, nand_o=1 at once.
- Assert rst_n=0 on the same edge as en=1, a=b=1 -> reset wins: nand_q=1, dec_o=1111, valid_o=0.
- With NAND_G_DECODER_STATS_EN and CNT_W=2: hold a=b=1, en=1 for 5 cycles -> low_cnt 1, 2, 3, 3, 3 (saturates). Without the macro, low_cnt stays 0.
- Random (a,b,en) for 200 cycles -> checker verifies nand_o == ~(a & b) at all times, the one-zero invariant on dec_o, and the one-cycle registered model.

Source files
------------

// File: rtl/nand_g_decoder.sv
// 2-input NAND with a registered 2-to-4 active-low decoder on sel = {b,a}.
// Optional saturating low-event counter enabled by NAND_G_DECODER_STATS_EN.
module nand_g_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  output logic             nand_o,
  output logic             nand_q,
  output logic [3:0]       dec_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] low_cnt
);

  localparam int unsigned DEC_W = 4;

  logic [1:0]       sel;
  logic             nand_d;
  logic [DEC_W-1:0] dec_d;
  logic [DEC_W-1:0] dec_q;
  logic             valid_d;
  logic             valid_q;

  // Zero-latency path; never touched by clk, rst_n or en.
  always_comb begin
    nand_o = ~(a & b);
  end

  assign sel = {b, a};

  // Next-state for the registered outputs; hold on idle cycles.
  always_comb begin
    nand_d  = nand_q;
    dec_d   = dec_q;
    valid_d = 1'b0;
    if (en) begin
      nand_d  = ~(a & b);
      valid_d = 1'b1;
      case (sel)
        2'd0:    dec_d = 4'b1110;
        2'd1:    dec_d = 4'b1101;
        2'd2:    dec_d = 4'b1011;
        default: dec_d = 4'b0111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nand_q  <= 1'b1;
      dec_q   <= {DEC_W{1'b1}};
      valid_q <= 1'b0;
    end else begin
      nand_q  <= nand_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
    end
  end

  assign dec_o   = dec_q;
  assign valid_o = valid_q;

`ifdef NAND_G_DECODER_STATS_EN
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Count enabled a=b=1 samples, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en && a && b && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign low_cnt = cnt_q;
`else
  assign low_cnt = '0;
`endif

endmodule

// File: tb/tb_nand_g_decoder.sv
// Scoreboard bench for nand_g_decoder: expectations queued at drive time, popped after the edge.
module tb_nand_g_decoder;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a = 1'b1;
  logic             b = 1'b1;
  logic             en = 1'b1;
  logic             nand_o;
  logic             nand_q;
  logic [3:0]       dec_o;
  logic             valid_o;
  logic [CNT_W-1:0] low_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic             nq;
    logic [3:0]       dec;
    logic             v;
    logic [CNT_W-1:0] cnt;
    logic             no;
  } exp_t;

  exp_t sb[$];

  // Independent reference state
  logic             m_nq = 1'b1;
  logic [3:0]       m_dec = 4'b1111;
  logic             m_v = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  nand_g_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
    .nand_o(nand_o), .nand_q(nand_q), .dec_o(dec_o),
    .valid_o(valid_o), .low_cnt(low_cnt)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus at the falling edge, queue the expectation, settle after the rise.
  task automatic drive(input logic ia, input logic ib, input logic ien, input logic irst_n);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; en = ien; rst_n = irst_n;
    if (!irst_n) begin
      m_nq = 1'b1; m_dec = 4'b1111; m_v = 1'b0; m_cnt = '0;
    end else if (ien) begin
      m_nq  = !(ia && ib);
      m_dec = 4'b1111;
      m_dec[{ib, ia}] = 1'b0;
      m_v   = 1'b1;
`ifdef NAND_G_DECODER_STATS_EN
      if (ia && ib && (m_cnt != 2'd3)) m_cnt = m_cnt + 2'd1;
`endif
    end else begin
      m_v = 1'b0;
    end
    e.nq = m_nq; e.dec = m_dec; e.v = m_v; e.cnt = m_cnt;
    e.no = !(ia && ib);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      tests_run++;
      if (nand_q !== 1'b1 || dec_o !== 4'b1111 || valid_o !== 1'b0 || low_cnt !== 2'd0 ||
          nand_q !== e.nq || dec_o !== e.dec) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got nq=%b dec=%b v=%b cnt=%0d, want nq=1 dec=1111 v=0 cnt=0",
                 i, nand_q, dec_o, valid_o, low_cnt);
      end
      tests_run++;
      if (nand_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_nand_o[%0d]: got %b want 0", i, nand_o);
      end
    end
  endtask

  task automatic test_decode();
    exp_t e;
    logic [3:0] dec_tab [4];
    logic       nand_tab[4];
    dec_tab[0] = 4'b1110; dec_tab[1] = 4'b1101; dec_tab[2] = 4'b1011; dec_tab[3] = 4'b0111;
    nand_tab[0] = 1'b1; nand_tab[1] = 1'b1; nand_tab[2] = 1'b1; nand_tab[3] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      logic [1:0] sv;
      sv = 2'(s);
      drive(sv[0], sv[1], 1'b1, 1'b1);
      e = sb.pop_front();
      tests_run++;
      if (nand_o !== nand_tab[s]) begin
        tests_failed++;
        $display("FAIL decode_nand_o sel=%0d: got %b want %b", s, nand_o, nand_tab[s]);
      end
      tests_run++;
      if (nand_q !== nand_tab[s] || dec_o !== dec_tab[s] || valid_o !== 1'b1 ||
          dec_o !== e.dec || nand_q !== e.nq) begin
        tests_failed++;
        $display("FAIL decode sel=%0d: got nq=%b dec=%b v=%b, want nq=%b dec=%b v=1",
                 s, nand_q, dec_o, valid_o, nand_tab[s], dec_tab[s]);
      end
    end
  endtask

  task automatic test_idle_hold();
    exp_t e;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    tests_run++;
    if (dec_o !== 4'b0111 || nand_q !== 1'b0 || valid_o !== 1'b0 ||
        dec_o !== e.dec || valid_o !== e.v) begin
      tests_failed++;
      $display("FAIL idle_hold: got nq=%b dec=%b v=%b, want nq=0 dec=0111 v=0",
               nand_q, dec_o, valid_o);
    end
    tests_run++;
    if (nand_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_nand_o: got %b want 1", nand_o);
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    e = sb.pop_front();
    tests_run++;
    if (nand_q !== 1'b1 || dec_o !== 4'b1111 || valid_o !== 1'b0 || low_cnt !== 2'd0 ||
        dec_o !== e.dec) begin
      tests_failed++;
      $display("FAIL reset_priority: got nq=%b dec=%b v=%b cnt=%0d, want nq=1 dec=1111 v=0 cnt=0",
               nand_q, dec_o, valid_o, low_cnt);
    end
  endtask

  task automatic test_stats();
    exp_t e;
    logic [CNT_W-1:0] want[5];
`ifdef NAND_G_DECODER_STATS_EN
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
`else
    for (int i = 0; i < 5; i++) want[i] = 2'd0;
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      e = sb.pop_front();
      tests_run++;
      if (low_cnt !== want[i] || low_cnt !== e.cnt || nand_q !== 1'b0) begin
        tests_failed++;
        $display("FAIL stats[%0d]: got cnt=%0d nq=%b, want cnt=%0d nq=0", i, low_cnt, nand_q, want[i]);
      end
    end
    // Counter holds while idle.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    e = sb.pop_front();
    tests_run++;
    if (low_cnt !== want[4] || valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stats_hold: got cnt=%0d v=%b, want cnt=%0d v=0", low_cnt, valid_o, want[4]);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   bad = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 200; i++) begin
      logic ra, rb, ren;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      ren = 1'($urandom_range(0, 1));
      drive(ra, rb, ren, 1'b1);
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL random_sb_empty at %0d", i);
        return;
      end
      e = sb.pop_front();
      tests_run++;
      if (nand_o !== e.no || nand_q !== e.nq || dec_o !== e.dec || valid_o !== e.v ||
          low_cnt !== e.cnt) begin
        tests_failed++;
        if (bad < 5)
          $display("FAIL random[%0d]: got no=%b nq=%b dec=%b v=%b cnt=%0d, want no=%b nq=%b dec=%b v=%b cnt=%0d",
                   i, nand_o, nand_q, dec_o, valid_o, low_cnt, e.no, e.nq, e.dec, e.v, e.cnt);
        bad++;
      end
      tests_run++;
      if (!(dec_o == 4'b1111 || $countones(~dec_o) == 1) || ((nand_q == 1'b0) != (dec_o[3] == 1'b0))) begin
        tests_failed++;
        $display("FAIL random_invariant[%0d]: nq=%b dec=%b", i, nand_q, dec_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_idle_hold();
    test_reset_priority();
    test_stats();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
